// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversampling and frame constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Ticks per bit period; the receiver hardware assumes exactly this value.
  localparam int UART_OVERSAMPLE = 16;

  // Data bits per 8N1 frame.
  localparam int UART_DATA_BITS = 8;

  // Sample-counter value at which the start bit is checked (mid start bit).
  localparam logic [3:0] UART_START_SAMPLE = 4'd7;

  // Sample-counter value at which data and stop bits are taken (bit centre,
  // one full bit period after the previous sample point).
  localparam logic [3:0] UART_BIT_SAMPLE = 4'd15;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and the register block.
// Latency: n/a (wires only).
// Backpressure: rx_ready from the consumer; rx_valid/rx_data hold while not ready.
// Signals: rx_data (byte), rx_valid (holding register full), rx_ready (accept).
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;

  // Receiver side: produces the byte, observes the accept.
  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  // Consumer side: observes the byte, drives the accept.
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Baud tick generator: one-cycle tick every div_q+1 clocks, shared by rx and tx.
// Latency: tick first asserts div_q+1 clocks after a clear.
// Backpressure: none; free running, restarted by clr_i.
// Ports: clk/rst (sync, active-high), clr_i (restart count), load_i (capture
// div_i into div_q), div_i (divisor), tick_o (one-cycle tick).
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q >= div_q) begin
      // >= rather than == so a smaller divisor loaded mid-count cannot make
      // the counter run all the way round before wrapping.
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load_i) begin
        div_q <= div_i;
      end
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == div_q);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: pin synchroniser, 16x start detect, deserialiser, 1-entry holding reg.
// Latency: byte valid D+152P+1 clocks after start-edge detect D (P = baud_div+1).
// Backpressure: rx_ready; a byte arriving while the holding reg is full and not accepted is dropped with an overrun pulse.
// Ports: clk/rst (sync, active-high); sin_i (async serial in, idle high);
// baud_div_i (tick every baud_div_i+1 clocks, captured in IDLE); rx_if (byte
// handshake, master side); frame_err_o / overrun_o (one-cycle error pulses);
// busy_o (receiver not idle).
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_i,
  input  logic [DIV_W-1:0] baud_div_i,
  uart_rx_if.master        rx_if,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam int SMP_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(UART_DATA_BITS);

  // Synchroniser and edge-detect delay; all reset high to match an idle line.
  logic sync1_q;
  logic s_q;
  logic s_dly_q;
  logic fall;

  uart_rx_state_t            state_q, state_d;
  logic [SMP_W-1:0]          samp_q, samp_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;

  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      ovr_q, ovr_d;

  logic tick;
  logic tick_clr;
  logic div_load;
  logic deliver;

  assign fall = s_dly_q & ~s_q;

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tick_clr),
    .load_i (div_load),
    .div_i  (baud_div_i),
    .tick_o (tick)
  );

  // Frame FSM: next state, counters, shift register.
  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tick_clr = 1'b0;
    div_load = 1'b0;
    deliver  = 1'b0;
    ferr_d   = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        // Divisor tracks the input only while idle, so a change cannot
        // disturb a frame in flight.
        div_load = 1'b1;
        if (fall) begin
          // Restart the tick phase at the edge so sample points line up
          // with bit centres.
          tick_clr = 1'b1;
          samp_d   = '0;
          state_d  = RX_START;
        end
      end

      RX_START: begin
        if (tick) begin
          if (samp_q == UART_START_SAMPLE) begin
            if (s_q) begin
              // Line back high mid start bit: treat as a glitch.
              state_d = RX_IDLE;
            end else begin
              samp_d  = '0;
              bit_d   = '0;
              state_d = RX_DATA;
            end
          end else begin
            samp_d = samp_q + SMP_W'(1);
          end
        end
      end

      RX_DATA: begin
        if (tick) begin
          // Wraps 15 -> 0 at each sample point, giving one bit period spacing.
          samp_d = samp_q + SMP_W'(1);
          if (samp_q == UART_BIT_SAMPLE) begin
            shift_d = {s_q, shift_q[UART_DATA_BITS-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
              state_d = RX_STOP;
            end
          end
        end
      end

      RX_STOP: begin
        if (tick) begin
          samp_d = samp_q + SMP_W'(1);
          if (samp_q == UART_BIT_SAMPLE) begin
            if (s_q) begin
              // Return at stop-bit centre so a following start edge is
              // never missed.
              deliver = 1'b1;
              state_d = RX_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = RX_WAIT_HIGH;
            end
          end
        end
      end

      RX_WAIT_HIGH: begin
        // Stay out of IDLE until the line recovers, so a break is not
        // seen as a string of start bits.
        if (s_q) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Holding register. A delivery in the same cycle as an accept replaces the
  // byte with no bubble; otherwise a full register drops the new byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (deliver) begin
      if (!valid_q || rx_if.rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_if.rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      s_q     <= 1'b1;
      s_dly_q <= 1'b1;
      state_q <= RX_IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= sin_i;
      s_q     <= sync1_q;
      s_dly_q <= s_q;
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign frame_err_o    = ferr_q;
  assign overrun_o      = ovr_q;
  assign busy_o         = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with an expected-byte queue.
module tb_uart_rx;

  logic        clk;
  logic        rst;
  logic        sin;
  logic [15:0] baud_div;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  uart_rx_if u_if ();

  uart_rx #(
    .OVERSAMPLE (16),
    .DIV_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sin_i       (sin),
    .baud_div_i  (baud_div),
    .rx_if       (u_if),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Error pulses are counted continuously so every pulse is seen.
  int fe_cnt = 0;
  int ov_cnt = 0;
  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int fall_cyc = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one 8N1 frame with a bit period of 16*p clocks. Must be entered at
  // a negedge; returns at a negedge with the line left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int p,
                            input bit push);
    if (push) exp_q.push_back(d);
    fall_cyc = cyc;
    sin = 1'b0;
    repeat (16 * p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sin = d[i];
      repeat (16 * p) @(negedge clk);
    end
    sin = stop;
    repeat (16 * p) @(negedge clk);
  endtask

  // Waits (bounded) for rx_valid; at_cyc is the cycle it was first seen.
  task automatic wait_valid(input string tag, input int budget, output int at_cyc);
    bit found;
    found  = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (u_if.rx_valid === 1'b1) begin
        found  = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic check_pop(input string tag);
    logic [7:0] e;
    chk({tag, "_queued"}, {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(tag, {24'd0, u_if.rx_data}, {24'd0, e});
    end
  endtask

  task automatic pulse_ready();
    u_if.rx_ready = 1'b1;
    @(negedge clk);
    u_if.rx_ready = 1'b0;
  endtask

  initial begin
    int t;
    rst           = 1'b1;
    sin           = 1'b1;
    baud_div      = 16'd0;
    u_if.rx_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_data",  {24'd0, u_if.rx_data}, 32'h00);
    chk("rst_valid", {31'd0, u_if.rx_valid}, 32'd0);
    chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
    chk("rst_ovr",   {31'd0, overrun}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte, 16-clock bit period: valid rises 155 clocks after the fall.
    fork
      send_frame(8'hA5, 1'b1, 1, 1'b1);
      begin
        wait_valid("a5_seen", 400, t);
        chk("a5_latency", t - fall_cyc, 32'd155);
        chk("a5_busy_low", {31'd0, busy}, 32'd0);
        check_pop("a5_data");
      end
    join
    chk("a5_ferr_cnt", fe_cnt, 32'd0);
    chk("a5_ovr_cnt",  ov_cnt, 32'd0);
    chk("a5_hold",     {24'd0, u_if.rx_data}, 32'hA5);
    pulse_ready();
    chk("a5_accepted", {31'd0, u_if.rx_valid}, 32'd0);

    // Back-to-back frames at baud_div=3 with the consumer keeping up.
    baud_div = 16'd3;
    @(negedge clk);
    fork
      begin
        send_frame(8'h00, 1'b1, 4, 1'b1);
        send_frame(8'hFF, 1'b1, 4, 1'b1);
        send_frame(8'h3C, 1'b1, 4, 1'b1);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_valid("b2b_seen", 1500, t);
          check_pop("b2b_data");
          @(negedge clk);
          pulse_ready();
        end
      end
    join
    chk("b2b_ovr_cnt", ov_cnt, 32'd0);
    chk("b2b_ferr_cnt", fe_cnt, 32'd0);
    chk("b2b_empty", {31'd0, u_if.rx_valid}, 32'd0);

    // Overrun: second byte dropped, first byte kept.
    baud_div = 16'd0;
    @(negedge clk);
    fork
      begin
        send_frame(8'h11, 1'b1, 1, 1'b1);
        send_frame(8'h22, 1'b1, 1, 1'b0);
      end
      begin
        wait_valid("ovr_seen", 400, t);
        check_pop("ovr_first");
      end
    join
    chk("ovr_cnt",   ov_cnt, 32'd1);
    chk("ovr_kept",  {24'd0, u_if.rx_data}, 32'h11);
    chk("ovr_valid", {31'd0, u_if.rx_valid}, 32'd1);
    pulse_ready();
    chk("ovr_drained", {31'd0, u_if.rx_valid}, 32'd0);

    // Accept and deliver in the same cycle.
    send_frame(8'h11, 1'b1, 1, 1'b1);
    chk("acc_first_valid", {31'd0, u_if.rx_valid}, 32'd1);
    check_pop("acc_first");
    fork
      send_frame(8'h22, 1'b1, 1, 1'b1);
      begin
        repeat (154) @(negedge clk);
        chk("acc_pending", {24'd0, u_if.rx_data}, 32'h11);
        u_if.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("acc_valid_kept", {31'd0, u_if.rx_valid}, 32'd1);
        check_pop("acc_replaced");
        @(negedge clk);
        u_if.rx_ready = 1'b0;
      end
    join
    chk("acc_no_ovr", ov_cnt, 32'd1);
    pulse_ready();
    chk("acc_drained", {31'd0, u_if.rx_valid}, 32'd0);

    // False start: 4-clock low glitch.
    sin = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    sin = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_idle",  {31'd0, busy}, 32'd0);
    chk("glitch_valid", {31'd0, u_if.rx_valid}, 32'd0);
    chk("glitch_ferr",  fe_cnt, 32'd0);

    // Framing error: stop bit low, line stays low afterwards.
    send_frame(8'h55, 1'b0, 1, 1'b0);
    chk("fe_cnt",     fe_cnt, 32'd1);
    chk("fe_valid",   {31'd0, u_if.rx_valid}, 32'd0);
    chk("fe_data",    {24'd0, u_if.rx_data}, 32'h22);
    chk("fe_no_ovr",  ov_cnt, 32'd1);
    chk("fe_busy",    {31'd0, busy}, 32'd1);
    repeat (40) @(negedge clk);
    chk("fe_busy_held", {31'd0, busy}, 32'd1);
    sin = 1'b1;
    repeat (4) @(negedge clk);
    chk("fe_recovered", {31'd0, busy}, 32'd0);

    // Reset in the middle of bit 4, held until the frame has passed.
    fork
      send_frame(8'h81, 1'b1, 1, 1'b0);
      begin
        repeat (16 * 5 + 8) @(negedge clk);
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_data",  {24'd0, u_if.rx_data}, 32'h00);
        chk("mid_rst_valid", {31'd0, u_if.rx_valid}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
        chk("mid_rst_ferr",  {31'd0, frame_err}, 32'd0);
        chk("mid_rst_ovr",   {31'd0, overrun}, 32'd0);
      end
    join
    rst = 1'b0;
    repeat (5) @(negedge clk);
    fork
      send_frame(8'h81, 1'b1, 1, 1'b1);
      begin
        wait_valid("post_rst_seen", 400, t);
        chk("post_rst_latency", t - fall_cyc, 32'd155);
        check_pop("post_rst_data");
      end
    join
    chk("post_rst_ferr", fe_cnt, 32'd1);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end for the SoC UART peripheral. Synchronises the external `uart_sin` pin, detects start bits with 16x oversampling, and deserialises 8N1 frames LSB first. Completed bytes are presented to the UART register block through a one-entry holding register with a valid/ready handshake. It also reports framing and overrun errors as single-cycle pulses.

## Interface
- `OVERSAMPLE`, 16: ticks per bit. Fixed; any other value is unsupported.
- `DIV_W`, 16: width of the baud divisor.
- `clk`  in  1  system clock. This is the only clock.
- `rst`  in  1  reset. Reset is synchronous and active-high.
- `sin`  in  1  raw serial input, asynchronous, idle high.
- `baud_div`  in  DIV_W  one tick every `baud_div+1` clocks. Captured only in IDLE.
- `rx_ready`  in  1  consumer accepts the byte in this cycle.
- `rx_data`  out  8  received byte. Reset value 0x00.
- `rx_valid`  out  1  holding register full. Reset value 0.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low. Reset value 0.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because the holding register is full. Reset value 0.
- `busy`  out  1  high in every state except IDLE. Reset value 0.

## Operation
- **Synchroniser:** two flops on `sin`, both reset to 1. Edge detection compares the second flop with a third delay flop, also reset to 1. All FSM logic uses the synchronised signal `s`.
- **Tick generator:**
  - Counts 0..div_q and pulses `tick` when the count equals div_q.
  - Is cleared in the cycle a start edge is detected.
  - div_q is loaded from `baud_div` on every IDLE cycle.
- **FSM:** states IDLE, START, DATA, STOP, WAIT_HIGH. Bit counter is 3 bits; sample counter is 4 bits and increments on `tick`.
  - **IDLE:** on a falling edge of `s`, clear the tick and sample counters and go to START.
  - **START:** when the sample counter equals 7 on a tick, sample `s`.
    - `s`=1: false start, return to IDLE with no output.
    - `s`=0: clear the sample counter and go to DATA.
  - **DATA:** when the sample counter equals 15 on a tick, shift `s` into bit[7] of the shift register (shift right). After the 8th bit go to STOP.
  - **STOP:** when the sample counter equals 15 on a tick, sample `s`.
    - `s`=1: deliver the byte and go to IDLE immediately, at stop-bit centre. This allows back-to-back frames.
    - `s`=0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - **WAIT_HIGH:** go to IDLE when `s`=1. This covers break and stuck-low lines, and prevents a falling edge being re-detected mid-break.
- **Holding register (byte delivery):**
  - If `rx_valid`=0, or `rx_valid`=1 with `rx_ready`=1 in the same cycle: load `rx_data` and set `rx_valid`=1.
  - If `rx_valid`=1 and `rx_ready`=0: keep the old byte, drop the new one, pulse `overrun`.
  - Otherwise, `rx_ready`=1 with `rx_valid`=1 clears `rx_valid`.
  - `rx_ready` while `rx_valid`=0 has no effect.
- **Errors:** framing errors never touch `rx_data` or `rx_valid`, and a framing error never produces an overrun pulse.
- **Reset:** reset at any point, including mid-frame, returns the FSM to IDLE, clears all counters and the holding register, and drives every output to its reset value on the next edge. A partial frame is lost.

## Timing
- **Sync latency:** 2 clocks from a `sin` change to `s`. Edge detection happens in the cycle `s` first reads 0.
- **Bit sampling:** with detection at cycle D and period P = `baud_div`+1, start is sampled at D+8P, data bit k at D+8P+16P(k+1), and stop at D+8P+144P.
- **Delivery:** `rx_valid`, `rx_data` and `overrun` update at D+152P+1. `frame_err` pulses at the same cycle.
- **Bit period:** 16P clocks. The next start edge can be detected from D+152P+1 onward.
- **Divisor changes:** a `baud_div` change mid-frame has no effect until the next IDLE.
- **Handshake:** `rx_valid` and `rx_data` are stable while `rx_valid`=1 and `rx_ready`=0, except that a simultaneous accept and deliver replaces the byte with no gap.

## Structure
- **Package `uart_pkg`:**
  - `uart_rx_state_t` enum with the five states.
  - `UART_OVERSAMPLE`=16.
  - Start-sample constant 7 and data/stop-sample constant 15.
  - `UART_DATA_BITS`=8.
- **Sub-module `uart_baud_tick`:** divisor counter with synchronous clear input and `tick` output. The future `uart_tx` will reuse it.
- **`uart_rx` contents:** synchroniser, FSM, shift register and holding register.

## Test plan
- **Single byte:** `baud_div`=0, send 0xA5 as 8N1 with a 16-clock bit period, `rx_ready`=0. Expect `rx_valid` rising exactly 155 clocks after the `sin` fall, `rx_data`=0xA5, no error pulses, `busy` low again at the same cycle.
- **Back-to-back:** `baud_div`=3, send 0x00, 0xFF, 0x3C consecutively with `rx_ready` pulsed on each `rx_valid`. Expect three deliveries in order, with correct values and no overrun.
- **Overrun:** `rx_ready`=0, send 0x11 then 0x22. Expect `rx_data` to stay 0x11 and one `overrun` pulse at the second stop centre. Then pulse `rx_ready`: `rx_valid` goes to 0.
- **Accept and deliver in the same cycle:** hold `rx_ready`=1 while 0x22 completes with 0x11 pending. Expect `rx_data`=0x22, `rx_valid` staying 1, no overrun.
- **False start and framing error:**
  - A 4-clock low glitch with `baud_div`=0 gives no output, and `busy` returns to 0 by about 10 clocks.
  - 0x55 with a low stop bit gives a `frame_err` pulse, `rx_valid` stays 0, and `busy` stays 1 until `sin` returns high.
- **Reset mid-frame:** assert `rst` during bit 4 of 0x81. Expect all outputs at their reset values the next cycle. A following clean 0x81 frame is received correctly.
